// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: op encodings, flag layout and control states.
package alu_pkg;

  localparam int ALU_OP_W = 3;

  // The first four encodings match the older 2-bit combinational ALU.
  typedef enum logic [ALU_OP_W-1:0] {
    OP_PASS = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_CLR  = 3'b011,
    OP_AND  = 3'b100,
    OP_OR   = 3'b101,
    OP_XOR  = 3'b110,
    OP_MUL  = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic n;
    logic v;
    logic c;
    logic z;
  } alu_flags_t;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier: one partial-product step per cycle, WIDTH steps.
// prod carries the value after the current step, so it holds the full product while done=1.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   prod
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  logic                 busy_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [WIDTH-1:0]     mcand_reg;
  logic [2*WIDTH-1:0]   prod_reg;

  logic [WIDTH-1:0]     addend;
  logic [WIDTH:0]       acc_sum;
  logic [2*WIDTH-1:0]   prod_step;

  // Upper half accumulates; lower half holds the multiplier bits still to be consumed.
  always_comb begin
    addend    = prod_reg[0] ? mcand_reg : '0;
    acc_sum   = {1'b0, prod_reg[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    prod_step = {acc_sum, prod_reg[WIDTH-1:1]};
  end

  assign done = busy_reg && (cnt_reg == LAST_ITER);
  assign prod = prod_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg  <= 1'b0;
      cnt_reg   <= '0;
      mcand_reg <= '0;
      prod_reg  <= '0;
    end else if (start) begin
      busy_reg  <= 1'b1;
      cnt_reg   <= '0;
      mcand_reg <= a;
      prod_reg  <= {{WIDTH{1'b0}}, b};
    end else if (busy_reg) begin
      prod_reg <= prod_step;
      if (cnt_reg == LAST_ITER) begin
        busy_reg <= 1'b0;
        cnt_reg  <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready on both sides; single-cycle ops complete on the accept
// edge, MUL runs through the shift-add sub-module and completes WIDTH edges later.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [ALU_OP_W-1:0] op,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    result,
  output logic [3:0]          flags
);

  alu_state_e   state_reg, state_next;
  logic         out_valid_reg, out_valid_next;
  logic [WIDTH-1:0] result_reg, result_next;
  alu_flags_t   flags_reg, flags_next;

  alu_op_e      op_e;
  logic         accept;
  logic         mul_sel;
  logic         mul_start;
  logic         mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  alu_flags_t       alu_flags;
  alu_flags_t       mul_flags;

  assign op_e    = alu_op_e'(op);
  assign mul_sel = MUL_EN && (op_e == OP_MUL);
  // Gated by rst_n so the port reads 0 while reset is held and 1 as soon as it lifts.
  assign in_ready = rst_n && (state_reg == IDLE) && (!out_valid_reg || out_ready);
  assign accept   = in_valid && in_ready;

  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign flags     = flags_reg;

  generate
    if (MUL_EN) begin : g_mul
      alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mul_start),
        .a     (a),
        .b     (b),
        .done  (mul_done),
        .prod  (mul_prod)
      );
    end else begin : g_no_mul
      assign mul_done = 1'b0;
      assign mul_prod = '0;
    end
  endgenerate

  // Single-cycle datapath; the extra adder bit yields carry (ADD) or borrow (SUB).
  always_comb begin
    sum_ext  = {1'b0, a} + {1'b0, b};
    diff_ext = {1'b0, a} - {1'b0, b};
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    case (op_e)
      OP_PASS: alu_res = a;
      OP_ADD: begin
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff_ext[WIDTH-1:0];
        alu_c   = diff_ext[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_CLR:  alu_res = '0;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_MUL:  alu_res = a;  // only reaches the output when the multiplier is absent
      default: alu_res = a;
    endcase
    alu_flags.n = alu_res[WIDTH-1];
    alu_flags.v = alu_v;
    alu_flags.c = alu_c;
    alu_flags.z = (alu_res == '0);

    mul_flags.n = mul_prod[WIDTH-1];
    mul_flags.v = 1'b0;
    mul_flags.c = |mul_prod[2*WIDTH-1:WIDTH];
    mul_flags.z = (mul_prod[WIDTH-1:0] == '0);
  end

  always_comb begin
    state_next     = state_reg;
    out_valid_next = out_valid_reg && !out_ready;
    result_next    = result_reg;
    flags_next     = flags_reg;
    mul_start      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (mul_sel) begin
            mul_start  = 1'b1;
            state_next = MUL_BUSY;
          end else begin
            out_valid_next = 1'b1;
            result_next    = alu_res;
            flags_next     = alu_flags;
          end
        end
      end
      MUL_BUSY: begin
        if (mul_done) begin
          state_next     = IDLE;
          out_valid_next = 1'b1;
          result_next    = mul_prod[WIDTH-1:0];
          flags_next     = mul_flags;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      flags_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      out_valid_reg <= out_valid_next;
      result_reg    <= result_next;
      flags_reg     <= flags_next;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: an arithmetic reference model feeds expected queues,
// a negedge monitor pops and compares on every output handshake.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, out_valid, out_ready;
  logic         in_valid0, in_ready0, out_valid0, out_ready0;
  logic [W-1:0] a, b, result, result0;
  logic [2:0]   op;
  logic [3:0]   flags, flags0;

  alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  alu_seq #(.WIDTH(W), .MUL_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .a(a), .b(b), .op(op), .out_valid(out_valid0), .out_ready(out_ready0),
    .result(result0), .flags(flags0)
  );

  typedef struct packed {
    logic [2:0]   o;
    logic [W-1:0] r;
    logic [3:0]   f;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp0_q[$];
  int   compared = 0;
  int   mismatched = 0;
  bit   rand_ready_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and two's-complement views.
  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x,
                                 input logic [W-1:0] y, input bit mul_en);
    exp_t e;
    int ux, uy, sx, sy, full, sres, r;
    bit c, v;
    ux = int'(x);
    uy = int'(y);
    sx = (ux >= 128) ? ux - 256 : ux;
    sy = (uy >= 128) ? uy - 256 : uy;
    r = 0; c = 1'b0; v = 1'b0;
    case (o)
      3'd0: r = ux;
      3'd1: begin
        full = ux + uy; r = full % 256; c = (full > 255);
        sres = sx + sy; v = (sres > 127) || (sres < -128);
      end
      3'd2: begin
        r = (ux - uy + 256) % 256; c = (ux < uy);
        sres = sx - sy; v = (sres > 127) || (sres < -128);
      end
      3'd3: r = 0;
      3'd4: r = ux & uy;
      3'd5: r = ux | uy;
      3'd6: r = ux ^ uy;
      default: begin
        if (mul_en) begin
          full = ux * uy; r = full % 256; c = (full > 255);
        end else begin
          r = ux;
        end
      end
    endcase
    e.o = o;
    e.r = W'(r);
    e.f = {(r >= 128), v, c, (r == 0)};
    return e;
  endfunction

  // Monitor: compare on each output transfer, and check held outputs under backpressure.
  bit           held = 1'b0;
  logic [W-1:0] held_r;
  logic [3:0]   held_f;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held && !out_valid) check("hold_valid", out_valid, 1);
      if (out_valid) begin
        if (held) begin
          check("hold_result", result, held_r);
          check("hold_flags", flags, held_f);
        end
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            check("spurious_out_valid", out_valid, 0);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("result op%0d", e.o), result, e.r);
            check($sformatf("flags op%0d", e.o), flags, e.f);
          end
          held = 1'b0;
        end else begin
          held = 1'b1; held_r = result; held_f = flags;
        end
      end else begin
        held = 1'b0;
      end
      if (out_valid0 && out_ready0) begin
        if (exp0_q.size() == 0) begin
          check("spurious_out_valid0", out_valid0, 0);
        end else begin
          e = exp0_q.pop_front();
          check($sformatf("result0 op%0d", e.o), result0, e.r);
          check($sformatf("flags0 op%0d", e.o), flags0, e.f);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
    if (rand_ready_en) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input bit to0, input logic [2:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, output int waited);
    a = x; b = y; op = o;
    if (to0) in_valid0 = 1'b1; else in_valid = 1'b1;
    waited = 0;
    forever begin
      @(negedge clk);
      if (to0 ? in_ready0 : in_ready) break;
      waited++;
      if (waited > 100) break;
      step();
    end
    if (waited > 100) begin
      check("issue_timeout", waited, 0);
    end else if (to0) begin
      exp0_q.push_back(model(o, x, y, 1'b0));
    end else begin
      exp_q.push_back(model(o, x, y, 1'b1));
    end
    step();
    in_valid = 1'b0;
    in_valid0 = 1'b0;
  endtask

  initial begin
    int w, lat, busy_cnt, stale, guard;
    logic [W-1:0] corners [4];
    logic [W-1:0] x, y;
    corners = '{8'h00, 8'h7F, 8'h80, 8'hFF};
    in_valid = 1'b0; in_valid0 = 1'b0; out_ready = 1'b0; out_ready0 = 1'b1;
    a = '0; b = '0; op = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_result", result, 0);
    check("reset_flags", flags, 0);
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", in_ready, 1);
    out_ready = 1'b1;
    step();

    // ADD wrap, SUB overflow, then a back-to-back SUB with borrow
    issue(1'b0, 3'd1, 8'hFF, 8'h01, w);
    issue(1'b0, 3'd2, 8'h80, 8'h01, w);
    issue(1'b0, 3'd2, 8'h01, 8'h02, w);
    check("b2b_wait_cycles", w, 0);

    // MUL latency: in_ready low for WIDTH cycles, result at edge N+WIDTH
    issue(1'b0, 3'd7, 8'h10, 8'h11, w);
    lat = 0; busy_cnt = 0;
    while (lat < 20) begin
      @(negedge clk);
      if (out_valid) break;
      if (!in_ready) busy_cnt++;
      lat++;
    end
    check("mul_latency", lat, W);
    check("mul_busy_cycles", busy_cnt, W);
    step();

    // Backpressure: held AND result, queued OR taken on the handshake edge
    out_ready = 1'b0;
    issue(1'b0, 3'd4, 8'hF0, 8'h3C, w);
    a = 8'h0F; b = 8'h81; op = 3'd5; in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_result", result, 8'h30);
    end
    step();
    out_ready = 1'b1;
    @(negedge clk);
    check("queued_accept", in_ready, 1);
    exp_q.push_back(model(3'd5, 8'h0F, 8'h81, 1'b1));
    step();
    in_valid = 1'b0;
    step();

    // Reset in the middle of a multiply
    issue(1'b0, 3'd7, 8'h37, 8'hA5, w);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    check("midmul_out_valid", out_valid, 0);
    check("midmul_result", result, 0);
    check("midmul_flags", flags, 0);
    check("midmul_in_ready", in_ready, 0);
    exp_q.delete();
    repeat (2) step();
    rst_n = 1'b1;
    #1;
    check("release_in_ready", in_ready, 1);
    check("release_out_valid", out_valid, 0);
    stale = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("stale_out_valid", stale, 0);
    step();

    // MUL_EN=0 instance: op 111 is a single-cycle PASS
    issue(1'b1, 3'd7, 8'h5A, 8'h03, w);
    @(negedge clk);
    check("nomul_single_cycle", out_valid0, 1);
    check("nomul_result", result0, 8'h5A);
    step();
    issue(1'b1, 3'd7, 8'h00, 8'hFF, w);
    issue(1'b1, 3'd1, 8'h7F, 8'h01, w);

    // Randomised traffic with random output backpressure
    rand_ready_en = 1'b1;
    for (int i = 0; i < 250; i++) begin
      x = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : W'($urandom_range(0, 255));
      y = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : W'($urandom_range(0, 255));
      issue($urandom_range(0, 7) == 0, 3'($urandom_range(0, 7)), x, y, w);
      if ($urandom_range(0, 3) == 0) step();
    end
    rand_ready_en = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while ((exp_q.size() != 0 || exp0_q.size() != 0) && guard < 200) begin
      step();
      guard++;
    end
    check("drain_queue", exp_q.size(), 0);
    check("drain_queue0", exp0_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the team's 2-bit-select combinational ALU.
- Keeps the existing op encodings: PASS, ADD, SUB, CLR.
- Adds logic ops, a multi-cycle shift-add multiply, status flags, and valid/ready handshakes on input and output.
- Sits between the datapath operand registers and the writeback stage.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
MUL_EN, 1, 1 = MUL op implemented; 0 = op 3'b111 executes as PASS

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous assert, active-low
in_valid  input  1  operands/op presented
in_ready  output  1  block can accept an operation this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
op  input  3  operation select (alu_pkg::alu_op_e)
out_valid  output  1  result/flags valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  operation result
flags  output  4  {N,V,C,Z} (alu_pkg::alu_flags_t)

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: in_ready=0 during reset, 1 in the first cycle after release; out_valid=0, result=0, flags=0, state=IDLE, counter=0.
- Op encoding:
  - 000 PASS: A
  - 001 ADD: A+B
  - 010 SUB: A-B
  - 011 CLR: 0
  - 100 AND
  - 101 OR
  - 110 XOR
  - 111 MUL: low WIDTH bits of A*B, unsigned
- Accept: a transfer occurs when in_valid && in_ready. in_ready = (state==IDLE) && (!out_valid || out_ready).
- Single-cycle ops:
  - Accepted at edge N; result, flags and out_valid=1 are registered at edge N.
  - Back-to-back issue at one op per cycle while out_ready=1.
- MUL (MUL_EN=1):
  - Accept moves state to MUL_BUSY and loads the multiplier sub-module.
  - WIDTH iterations of shift-add, one per cycle.
  - Result registered and out_valid=1 at edge N+WIDTH; state returns to IDLE at that edge.
  - in_ready=0 throughout MUL_BUSY.
- State machine:
  - IDLE -> MUL_BUSY on MUL accept.
  - MUL_BUSY -> IDLE when the iteration counter reaches WIDTH-1.
  - There is no other state; output hold is expressed by out_valid.
- Output handshake:
  - While out_valid && !out_ready, result and flags are held stable and no new op is accepted.
  - out_valid drops on the handshake edge unless a new op completes on the same edge. In that case out_valid stays 1 with the new data.
- Flags:
  - Z = (result==0) for all ops.
  - N = result[WIDTH-1].
  - ADD: C = carry-out; V = signed overflow (operands same sign, result sign differs).
  - SUB: C = borrow (A<B unsigned); V = signed overflow (operands differ in sign, result sign differs from A).
  - PASS/CLR/logic ops: C=0, V=0.
  - MUL: C = any of the upper WIDTH product bits nonzero; V=0.
  - CLR: result 0, so Z=1 and N=0.
- Arithmetic is modulo 2^WIDTH; the internal ADD/SUB adder is WIDTH+1 bits.
- Multiply product register is 2*WIDTH bits. The iteration counter is $clog2(WIDTH) bits and wraps to 0 on completion.
- rst_n asserted mid-MUL: the operation is aborted immediately and all state/outputs take reset values. No result is produced after release.
- op changes or in_valid toggles while in_ready=0: ignored, with no effect on the in-flight op.
- MUL_EN=0: op 111 is a single-cycle PASS with C=V=0, and MUL_BUSY is unreachable.

Decomposition:
- alu_pkg:
  - alu_op_e: 3-bit enum, encodings above.
  - alu_flags_t: packed struct {n,v,c,z}.
  - alu_state_e: IDLE, MUL_BUSY.
  - localparam ALU_OP_W = 3.
- Sub-module alu_mul_seq:
  - Parametrised by WIDTH.
  - Ports: start, a, b -> done, prod[2*WIDTH-1:0].
  - Owns the shift-add datapath and the iteration counter.
- alu_seq owns the handshake, the single-cycle ops, flag generation and the output register.

Test Plan:
- WIDTH=8, ADD a=0xFF b=0x01, out_ready=1 -> next cycle out_valid=1, result=0x00, flags Z=1 C=1 V=0 N=0.
- SUB a=0x80 b=0x01 -> result=0x7F, V=1 C=0 N=0 Z=0. Then SUB a=0x01 b=0x02 on the next cycle -> result=0xFF, C=1 N=1 V=0 (back-to-back, in_ready held 1).
- MUL a=0x10 b=0x11 accepted at edge N -> in_ready=0 for 8 cycles; out_valid at edge N+8, result=0x10, C=1, Z=0.
- Backpressure: AND a=0xF0 b=0x3C with out_ready=0 for 5 cycles -> result=0x30 stable and in_ready=0 throughout. out_ready=1 -> handshake, with a queued OR accepted the same cycle.
- Reset mid-MUL: assert rst_n=0 at iteration 4 -> out_valid=0 and result=0 asynchronously. After release: in_ready=1, no stale out_valid.
- MUL_EN=0: op=111 a=0x5A b=0x03 -> single-cycle result=0x5A, C=0 V=0.
